wshbn_block_bridge: RTL and testbench
=====================================

Name: wshbn_block_bridge

Overview:
- Converts one cache-line memory request (BLOCK_SIZE words, block address, rw flag) into a Wishbone classic word-beat burst. On completion it returns a one-cycle acknowledge with the assembled read line.
- Sits between the cache controller's allocate/write_back states and the Wishbone RAM.
- Successor to the fixed-size block port: word width, address width, line length and byte selects are all parametrised, and it adds error termination and a busy flag.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- WORD_WIDTH, 32, data word width; must be a multiple of 8.
- BLOCK_SIZE, 4, words per line; must be a power of 2, at least 2.
- TIMEOUT_CYCLES, 16, per-beat ack watchdog limit; used only with the optional feature.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- req_cs  in  1  request valid; sampled only in IDLE
- req_rw  in  1  0 = read line, 1 = write line
- req_addr  in  ADDR_WIDTH  byte address; low offset bits ignored
- req_data  in  BLOCK_SIZE*WORD_WIDTH  write line; word i at bits [i*WORD_WIDTH +: WORD_WIDTH]
- resp_ack  out  1  one-cycle completion pulse
- resp_err  out  1  valid with resp_ack; the burst was aborted
- resp_data  out  BLOCK_SIZE*WORD_WIDTH  read line, same packing as req_data
- busy  out  1  high from acceptance until resp_ack
- wb_cyc_o  out  1  Wishbone cycle
- wb_stb_o  out  1  Wishbone strobe
- wb_we_o  out  1  Wishbone write enable
- wb_adr_o  out  ADDR_WIDTH  Wishbone address
- wb_sel_o  out  WORD_WIDTH/8  byte selects; all ones during a beat
- wb_dat_o  out  WORD_WIDTH  Wishbone write data
- wb_dat_i  in  WORD_WIDTH  Wishbone read data
- wb_ack_i  in  1  Wishbone beat acknowledge
- wb_err_i  in  1  Wishbone beat error

Behaviour:
- Reset, synchronous on rst_n = 0 at a clock edge: state IDLE, beat counter 0. All outputs 0, including resp_data.
- Reset mid-burst: wb_cyc_o, wb_stb_o and busy are 0 from the next edge. No resp_ack is issued. A partially filled resp_data is cleared.
- FSM states: IDLE, BURST, DONE.
- IDLE -> BURST when req_cs = 1 at a clock edge. On that edge:
  - latch req_rw, req_data, and the base address = req_addr with its low log2(BLOCK_SIZE*WORD_WIDTH/8) bits cleared;
  - set busy = 1, beat = 0.
- BURST outputs, registered:
  - wb_cyc_o = wb_stb_o = 1;
  - wb_adr_o = base + beat*(WORD_WIDTH/8);
  - wb_we_o = latched rw;
  - wb_dat_o = latched word[beat].
- Each beat completes at an edge where wb_ack_i = 1. On that edge:
  - for reads, store wb_dat_i into resp_data word[beat];
  - if beat = BLOCK_SIZE-1, go to DONE; otherwise increment beat. The new address and data appear the next cycle with stb still high.
- wb_err_i = 1 at an edge in BURST: abort, set the error flag, go to DONE.
- If wb_ack_i and wb_err_i are high together, err wins.
- DONE, one cycle:
  - wb_cyc_o = wb_stb_o = 0;
  - resp_ack = 1, resp_err = error flag, busy = 0.
  - Next state is IDLE.
- resp_data holds its value until the next read beat overwrites it. On error, words not yet received keep their previous contents.
- Latency with a slave that acks every cycle: acceptance edge T0; stb high in cycles T0+1 .. T0+BLOCK_SIZE; resp_ack high in cycle T0+BLOCK_SIZE+1. Each slave wait state adds one cycle.
- Back-to-back: a request held on req_cs is re-sampled in the IDLE cycle after DONE. Minimum request-to-request spacing is BLOCK_SIZE+2 cycles.
- req_* inputs may change freely after the acceptance edge.
- Address arithmetic wraps modulo 2^ADDR_WIDTH. Bursts never cross a line because the base is line-aligned.

Optional Feature:
- Macro: WSHBN_BRIDGE_TIMEOUT_EN.
- Defined: a wait counter resets to 0 at acceptance and on every beat ack, and increments each BURST cycle without ack or err. When the counter reaches TIMEOUT_CYCLES it is treated exactly like wb_err_i: abort, resp_err = 1.
- Undefined: no counter. The bridge waits indefinitely for ack or err, and TIMEOUT_CYCLES is unused.

Decomposition:
- Add bridge_state_t {idle, burst, done} to shared package wshbn_ports_defs. Place it alongside cache_state_t.
- Add derived constants BYTES_PER_WORD and LINE_OFFSET_BITS to cache_parameters.
- One sub-module, wshbn_beat_watchdog: the wait counter with clear, count and expired outputs. It is instantiated only under WSHBN_BRIDGE_TIMEOUT_EN.

Test Plan (ADDR_WIDTH=32, WORD_WIDTH=32, BLOCK_SIZE=4):
- Read: req_addr=0x0000_0104, slave acks every cycle with 0xA0, 0xA1, 0xA2, 0xA3 -> wb_adr_o sequence 0x100, 0x104, 0x108, 0x10C, wb_sel_o=0xF. resp_ack in cycle T0+5, resp_data words {0xA0, 0xA1, 0xA2, 0xA3}, resp_err=0.
- Write: req_addr=0x200, req_data words {0x11, 0x22, 0x33, 0x44}, slave adds 2 wait states per beat -> wb_we_o=1, wb_dat_o 0x11..0x44 in order, each held 3 cycles. resp_ack in cycle T0+13.
- Error: wb_err_i asserted on beat 2 -> cyc/stb low next cycle, no 4th address issued. resp_ack=1 with resp_err=1; resp_data words 0 and 1 updated.
- Reset mid-burst: rst_n=0 during beat 1 -> all outputs 0 after that edge, no resp_ack. A fresh read then completes normally.
- Back-to-back: req_cs held high across two reads -> second acceptance in the cycle after resp_ack, at spacing 6 cycles.
- Timeout (macro on, TIMEOUT_CYCLES=8): slave never acks -> after 8 stalled cycles cyc drops, resp_ack=1 and resp_err=1. With the macro off, the bridge stays busy indefinitely.

Source files
------------

// File: rtl/wshbn_block_bridge_pkg.sv
// Shared cache/bridge state types and line-geometry helpers used by wshbn_block_bridge.
// cache_state_t belongs to the cache controller and is not referenced by the bridge.
package wshbn_ports_defs;

  typedef enum logic [1:0] {cache_idle, compare_tag, allocate, write_back} cache_state_t;
  typedef enum logic [1:0] {idle, burst, done} bridge_state_t;

endpackage

package cache_parameters;

  localparam int CACHE_WORD_WIDTH = 32;
  localparam int CACHE_BLOCK_SIZE = 4;
  localparam int BYTES_PER_WORD   = CACHE_WORD_WIDTH / 8;
  localparam int LINE_OFFSET_BITS = $clog2(CACHE_BLOCK_SIZE * BYTES_PER_WORD);

  // These let a parametrised instance derive its own geometry.
  function automatic int bytes_per_word(input int word_width);
    return word_width / 8;
  endfunction

  function automatic int line_offset_bits(input int block_size, input int word_width);
    return $clog2(block_size * (word_width / 8));
  endfunction

endpackage

// File: rtl/wshbn_block_bridge_watchdog.sv
// Per-beat wait counter for wshbn_block_bridge; only instantiated when
// WSHBN_BRIDGE_TIMEOUT_EN is defined.
module wshbn_beat_watchdog #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic count_i,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (count_i) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Fires on the stalled cycle whose edge takes the count to TIMEOUT_CYCLES.
  assign expired_o = count_i && !clear_i && (count_q == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/wshbn_block_bridge.sv
// Cache-line to Wishbone classic word-burst bridge with error abort and busy flag.
// Optional per-beat ack watchdog enabled by defining WSHBN_BRIDGE_TIMEOUT_EN.
module wshbn_block_bridge
  import wshbn_ports_defs::*;
  import cache_parameters::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int WORD_WIDTH     = 32,
  parameter int BLOCK_SIZE     = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            req_cs,
  input  logic                            req_rw,
  input  logic [ADDR_WIDTH-1:0]           req_addr,
  input  logic [BLOCK_SIZE*WORD_WIDTH-1:0] req_data,
  output logic                            resp_ack,
  output logic                            resp_err,
  output logic [BLOCK_SIZE*WORD_WIDTH-1:0] resp_data,
  output logic                            busy,
  output logic                            wb_cyc_o,
  output logic                            wb_stb_o,
  output logic                            wb_we_o,
  output logic [ADDR_WIDTH-1:0]           wb_adr_o,
  output logic [WORD_WIDTH/8-1:0]         wb_sel_o,
  output logic [WORD_WIDTH-1:0]           wb_dat_o,
  input  logic [WORD_WIDTH-1:0]           wb_dat_i,
  input  logic                            wb_ack_i,
  input  logic                            wb_err_i
);

  localparam int WORD_BYTES  = bytes_per_word(WORD_WIDTH);
  localparam int OFFSET_BITS = line_offset_bits(BLOCK_SIZE, WORD_WIDTH);
  localparam int BEAT_W      = $clog2(BLOCK_SIZE);
  localparam int LINE_W      = BLOCK_SIZE * WORD_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK =
    ~((ADDR_WIDTH'(1) << OFFSET_BITS) - ADDR_WIDTH'(1));
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BLOCK_SIZE - 1);

  if (BLOCK_SIZE < 2 || (BLOCK_SIZE & (BLOCK_SIZE - 1)) != 0 ||
      (WORD_WIDTH % 8) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("wshbn_block_bridge: unsupported parameter combination");
  end

  bridge_state_t          state_q, state_d;
  logic [BEAT_W-1:0]      beat_q, beat_d;
  logic [ADDR_WIDTH-1:0]  base_q, base_d;
  logic                   rw_q, rw_d;
  logic [LINE_W-1:0]      line_q, line_d;
  logic                   err_q, err_d;
  logic [LINE_W-1:0]      resp_data_q, resp_data_d;
  logic                   timeout_w;
  logic                   abort_w;

`ifdef WSHBN_BRIDGE_TIMEOUT_EN
  wshbn_beat_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   ((state_q != burst) || wb_ack_i),
    .count_i   ((state_q == burst) && !wb_ack_i && !wb_err_i),
    .expired_o (timeout_w)
  );
`else
  assign timeout_w = 1'b0;
`endif

  assign abort_w = wb_err_i || timeout_w;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= idle;
      beat_q      <= '0;
      base_q      <= '0;
      rw_q        <= 1'b0;
      line_q      <= '0;
      err_q       <= 1'b0;
      resp_data_q <= '0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      base_q      <= base_d;
      rw_q        <= rw_d;
      line_q      <= line_d;
      err_q       <= err_d;
      resp_data_q <= resp_data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    base_d      = base_q;
    rw_d        = rw_q;
    line_d      = line_q;
    err_d       = err_q;
    resp_data_d = resp_data_q;
    unique case (state_q)
      idle: begin
        if (req_cs) begin
          state_d = burst;
          beat_d  = '0;
          base_d  = req_addr & LINE_MASK;
          rw_d    = req_rw;
          line_d  = req_data;
          err_d   = 1'b0;
        end
      end
      burst: begin
        // Error takes priority over a simultaneous ack; the beat is not stored.
        if (abort_w) begin
          err_d   = 1'b1;
          state_d = done;
        end else if (wb_ack_i) begin
          if (!rw_q) begin
            resp_data_d[beat_q*WORD_WIDTH +: WORD_WIDTH] = wb_dat_i;
          end
          if (beat_q == LAST_BEAT) begin
            state_d = done;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end
      done:    state_d = idle;
      default: state_d = idle;
    endcase
  end

  always_comb begin
    wb_cyc_o = 1'b0;
    wb_stb_o = 1'b0;
    wb_we_o  = 1'b0;
    wb_adr_o = '0;
    wb_sel_o = '0;
    wb_dat_o = '0;
    resp_ack = 1'b0;
    resp_err = 1'b0;
    busy     = 1'b0;
    unique case (state_q)
      burst: begin
        wb_cyc_o = 1'b1;
        wb_stb_o = 1'b1;
        wb_we_o  = rw_q;
        wb_adr_o = base_q + ADDR_WIDTH'(beat_q) * ADDR_WIDTH'(WORD_BYTES);
        wb_sel_o = '1;
        wb_dat_o = line_q[beat_q*WORD_WIDTH +: WORD_WIDTH];
        busy     = 1'b1;
      end
      done: begin
        resp_ack = 1'b1;
        resp_err = err_q;
      end
      default: ;
    endcase
  end

  assign resp_data = resp_data_q;

endmodule

// File: tb/tb_wshbn_block_bridge.sv
// Scoreboard bench for wshbn_block_bridge: directed line requests against a
// behavioural Wishbone slave; a monitor checks every resp_ack against queued expectations.
module tb_wshbn_block_bridge;

  localparam int AW = 32;
  localparam int WW = 32;
  localparam int BS = 4;
  localparam int LW = BS * WW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_cs = 1'b0;
  logic          req_rw = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [LW-1:0] req_data = '0;
  logic          resp_ack, resp_err, busy;
  logic [LW-1:0] resp_data;
  logic          wb_cyc_o, wb_stb_o, wb_we_o;
  logic [AW-1:0] wb_adr_o;
  logic [WW/8-1:0] wb_sel_o;
  logic [WW-1:0] wb_dat_o;
  logic [WW-1:0] wb_dat_i = '0;
  logic          wb_ack_i = 1'b0;
  logic          wb_err_i = 1'b0;

  always #5 clk = ~clk;

  wshbn_block_bridge #(
    .ADDR_WIDTH(AW), .WORD_WIDTH(WW), .BLOCK_SIZE(BS), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_cs(req_cs), .req_rw(req_rw), .req_addr(req_addr), .req_data(req_data),
    .resp_ack(resp_ack), .resp_err(resp_err), .resp_data(resp_data), .busy(busy),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_adr_o(wb_adr_o),
    .wb_sel_o(wb_sel_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
  );

  int tests = 0;
  int fails = 0;
  int cyc_n = 0;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Behavioural slave: fixed wait states per beat, read data = base + word index.
  int          sl_wait = 0;
  int          sl_err_beat = -1;
  bit          sl_hang = 1'b0;
  logic [31:0] sl_rd_base = '0;
  int          sl_cnt = 0;
  logic [31:0] log_adr[$];
  logic [31:0] log_dat[$];
  logic        log_we[$];
  logic [3:0]  log_sel[$];

  always @(negedge clk) begin
    wb_ack_i = 1'b0;
    wb_err_i = 1'b0;
    wb_dat_i = '0;
    if (wb_cyc_o && wb_stb_o && !sl_hang) begin
      if (sl_cnt == sl_wait) begin
        sl_cnt = 0;
        log_adr.push_back(wb_adr_o);
        log_dat.push_back(wb_dat_o);
        log_we.push_back(wb_we_o);
        log_sel.push_back(wb_sel_o);
        if (int'(wb_adr_o[3:2]) == sl_err_beat) begin
          wb_err_i = 1'b1;
        end else begin
          wb_ack_i = 1'b1;
          wb_dat_i = sl_rd_base + 32'(wb_adr_o[3:2]);
        end
      end else begin
        sl_cnt++;
      end
    end else begin
      sl_cnt = 0;
    end
  end

  typedef struct {
    string         name;
    logic          err;
    logic [LW-1:0] data;
    int            lat;
  } exp_t;

  exp_t sb[$];
  int   rise_q[$];
  int   last_rise = 0;
  logic busy_prev = 1'b0;

  // Monitor: latency is counted from the first busy cycle (cycle T0+1).
  always @(negedge clk) begin
    exp_t e;
    if (busy === 1'b1 && busy_prev !== 1'b1) begin
      last_rise = cyc_n;
      rise_q.push_back(cyc_n);
    end
    busy_prev = busy;
    if (resp_ack === 1'b1) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_ack: got resp_ack=1 expected no response (cycle %0d)", cyc_n);
      end else begin
        e = sb.pop_front();
        $display("[TB] resp %s err=%0b data=0x%0h cycle=%0d", e.name, resp_err, resp_data, cyc_n);
        check({e.name, "_err"}, LW'(resp_err), LW'(e.err));
        check({e.name, "_data"}, resp_data, e.data);
        check({e.name, "_cyc_low"}, LW'(wb_cyc_o), LW'(0));
        if (e.lat != 0) check({e.name, "_lat"}, LW'(cyc_n - last_rise + 1), LW'(e.lat));
      end
    end
  end

  task automatic push_exp(input string name, input logic err, input logic [LW-1:0] data, input int lat);
    exp_t e;
    e.name = name; e.err = err; e.data = data; e.lat = lat;
    sb.push_back(e);
  endtask

  task automatic issue(input logic [AW-1:0] addr, input logic rw, input logic [LW-1:0] data);
    @(negedge clk);
    req_cs = 1'b1; req_rw = rw; req_addr = addr; req_data = data;
    @(negedge clk);
    req_cs = 1'b0; req_rw = ~rw; req_addr = 32'hDEAD_BEEF; req_data = {4{32'h5A5A_5A5A}};
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: got %0d pending responses expected 0", name, sb.size());
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic clear_logs();
    log_adr.delete(); log_dat.delete(); log_we.delete(); log_sel.delete();
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check("rst_cyc", LW'(wb_cyc_o), LW'(0));
    check("rst_busy", LW'(busy), LW'(0));
    check("rst_ack", LW'(resp_ack), LW'(0));
    check("rst_adr", LW'(wb_adr_o), LW'(0));
    check("rst_data", resp_data, LW'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Read line at 0x104 -> aligned base 0x100, zero wait states.
    clear_logs(); sl_wait = 0; sl_rd_base = 32'hA0;
    push_exp("read", 1'b0, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 5);
    issue(32'h0000_0104, 1'b0, '0);
    drain("read");
    check("read_beats", LW'(log_adr.size()), LW'(4));
    for (int i = 0; i < 4; i++) begin
      check($sformatf("read_adr%0d", i), LW'(log_adr[i]), LW'(32'h100 + 4 * i));
      check($sformatf("read_sel%0d", i), LW'(log_sel[i]), LW'(4'hF));
      check($sformatf("read_we%0d", i), LW'(log_we[i]), LW'(0));
    end

    // Write line at 0x200 with two wait states; read line must be untouched.
    clear_logs(); sl_wait = 2; sl_rd_base = 32'hEE;
    push_exp("write", 1'b0, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 13);
    issue(32'h0000_0200, 1'b1, {32'h44, 32'h33, 32'h22, 32'h11});
    drain("write");
    check("write_beats", LW'(log_adr.size()), LW'(4));
    for (int i = 0; i < 4; i++) begin
      check($sformatf("write_adr%0d", i), LW'(log_adr[i]), LW'(32'h200 + 4 * i));
      check($sformatf("write_dat%0d", i), LW'(log_dat[i]), LW'(32'h11 * (i + 1)));
      check($sformatf("write_we%0d", i), LW'(log_we[i]), LW'(1));
    end

    // Error on beat 2: words 0,1 updated, words 2,3 keep old contents.
    clear_logs(); sl_wait = 0; sl_rd_base = 32'hB0; sl_err_beat = 2;
    push_exp("error", 1'b1, {32'hA3, 32'hA2, 32'hB1, 32'hB0}, 4);
    issue(32'h0000_0300, 1'b0, '0);
    drain("error");
    sl_err_beat = -1;
    check("error_beats", LW'(log_adr.size()), LW'(3));

    // Reset during beat 1: no response, everything cleared.
    clear_logs(); sl_wait = 3; sl_rd_base = 32'hC0;
    issue(32'h0000_0400, 1'b0, '0);
    n = 0;
    while (wb_adr_o !== 32'h404 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("midrst_reach_beat1", LW'(wb_adr_o), LW'(32'h404));
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_cyc", LW'(wb_cyc_o), LW'(0));
    check("midrst_stb", LW'(wb_stb_o), LW'(0));
    check("midrst_busy", LW'(busy), LW'(0));
    check("midrst_ack", LW'(resp_ack), LW'(0));
    check("midrst_data", resp_data, LW'(0));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    sl_wait = 0;
    push_exp("postrst", 1'b0, {32'hC3, 32'hC2, 32'hC1, 32'hC0}, 5);
    issue(32'h0000_0408, 1'b0, '0);
    drain("postrst");

    // Back-to-back reads with req_cs held high.
    sl_rd_base = 32'hD0;
    push_exp("b2b_0", 1'b0, {32'hD3, 32'hD2, 32'hD1, 32'hD0}, 5);
    push_exp("b2b_1", 1'b0, {32'hD3, 32'hD2, 32'hD1, 32'hD0}, 5);
    rise_q.delete();
    @(negedge clk);
    req_cs = 1'b1; req_rw = 1'b0; req_addr = 32'h500;
    n = 0;
    while (rise_q.size() < 2 && n < 40) begin
      @(negedge clk);
      n++;
    end
    req_cs = 1'b0;
    check("b2b_accepts", LW'(rise_q.size()), LW'(2));
    if (rise_q.size() >= 2) check("b2b_spacing", LW'(rise_q[1] - rise_q[0]), LW'(6));
    drain("b2b");

`ifdef WSHBN_BRIDGE_TIMEOUT_EN
    // Slave never responds: watchdog aborts after 8 stalled cycles.
    sl_hang = 1'b1;
    push_exp("timeout", 1'b1, {32'hD3, 32'hD2, 32'hD1, 32'hD0}, 9);
    issue(32'h0000_0600, 1'b0, '0);
    drain("timeout");
    sl_hang = 1'b0;
`else
    // Without the watchdog a silent slave leaves the bridge busy.
    sl_hang = 1'b1;
    issue(32'h0000_0600, 1'b0, '0);
    repeat (40) @(negedge clk);
    check("hang_busy", LW'(busy), LW'(1));
    check("hang_cyc", LW'(wb_cyc_o), LW'(1));
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    sl_hang = 1'b0;
    check("hang_rst_busy", LW'(busy), LW'(0));
    repeat (2) @(negedge clk);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
